// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: fractional-N baud tick generator producing oversample and bit ticks.
// Revision: 1.0
`default_nettype none

module uart_baud_gen_frac #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FRAC_BITS  = 4,
  parameter int DIV_W      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_resync,
  input  logic [DIV_W-1:0]     i_div_int,
  input  logic [FRAC_BITS-1:0] i_div_frac,
  input  logic                 i_div_load,
  output logic                 o_tick_os,
  output logic                 o_tick_1x,
  output logic                 o_load_pending
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [63:0] DEF_INT_64 =
    64'(CLK_FREQ) / (64'(BAUD_RATE) * 64'(OVERSAMPLE));
  localparam logic [63:0] DEF_FRAC_64 =
    ((64'(CLK_FREQ) << FRAC_BITS) / (64'(BAUD_RATE) * 64'(OVERSAMPLE))) % (64'd1 << FRAC_BITS);
  localparam logic [DIV_W-1:0]     DEF_INT  = DEF_INT_64[DIV_W-1:0];
  localparam logic [FRAC_BITS-1:0] DEF_FRAC = DEF_FRAC_64[FRAC_BITS-1:0];
  localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0]     MIN_INT  = DIV_W'(2);

  logic [DIV_W-1:0]     act_int;
  logic [FRAC_BITS-1:0] act_frac;
  logic [DIV_W-1:0]     shd_int;
  logic [FRAC_BITS-1:0] shd_frac;
  logic                 pending;
  logic [FRAC_BITS-1:0] acc;
  logic [DIV_W:0]       cnt;
  logic [DIV_W:0]       len;
  logic [OS_W-1:0]      os_cnt;
  logic                 tick_os;
  logic                 tick_1x;

  logic [DIV_W-1:0]     eff_int;
  logic [FRAC_BITS-1:0] eff_frac;
  logic [DIV_W-1:0]     use_int;
  logic [FRAC_BITS:0]   acc_sum;
  logic [DIV_W:0]       new_len;
  logic                 period_start;
  logic                 period_end;
  logic                 os_wrap;

  // A load in the same cycle as a period start takes effect for that period.
  always_comb begin
    eff_int  = act_int;
    eff_frac = act_frac;
    if (i_div_load) begin
      eff_int  = i_div_int;
      eff_frac = i_div_frac;
    end else if (pending) begin
      eff_int  = shd_int;
      eff_frac = shd_frac;
    end
  end

  always_comb begin
    use_int      = (eff_int < MIN_INT) ? MIN_INT : eff_int;
    acc_sum      = {1'b0, acc} + {1'b0, eff_frac};
    new_len      = {1'b0, use_int} + (DIV_W+1)'(acc_sum[FRAC_BITS]);
    period_start = (cnt == '0);
    period_end   = !period_start && (cnt == len - (DIV_W+1)'(1));
    os_wrap      = (os_cnt == OS_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      act_int  <= DEF_INT;
      act_frac <= DEF_FRAC;
      shd_int  <= '0;
      shd_frac <= '0;
      pending  <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      len      <= '0;
      os_cnt   <= '0;
      tick_os  <= 1'b0;
      tick_1x  <= 1'b0;
    end else begin
      tick_os <= 1'b0;
      tick_1x <= 1'b0;
      if (i_div_load) begin
        shd_int  <= i_div_int;
        shd_frac <= i_div_frac;
        pending  <= 1'b1;
      end
      if (!i_en || i_resync) begin
        cnt      <= '0;
        acc      <= '0;
        os_cnt   <= '0;
        act_int  <= eff_int;
        act_frac <= eff_frac;
        pending  <= 1'b0;
      end else if (period_start) begin
        // Period length is fixed here, so a period never mixes two divisors.
        act_int  <= eff_int;
        act_frac <= eff_frac;
        pending  <= 1'b0;
        acc      <= acc_sum[FRAC_BITS-1:0];
        len      <= new_len;
        cnt      <= (DIV_W+1)'(1);
      end else if (period_end) begin
        tick_os <= 1'b1;
        tick_1x <= os_wrap;
        os_cnt  <= os_wrap ? '0 : os_cnt + OS_W'(1);
        cnt     <= '0;
      end else begin
        cnt <= cnt + (DIV_W+1)'(1);
      end
    end
  end

  assign o_tick_os      = tick_os;
  assign o_tick_1x      = tick_1x;
  assign o_load_pending = pending;

endmodule

`default_nettype wire

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench: expected tick cycles are queued when stimulus is applied and popped per tick.
`default_nettype none

module tb_uart_baud_gen_frac;

  localparam int FR = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, resync = 1'b0, load = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic tick_os, tick_1x, pending;
  logic en1 = 1'b0, resync1 = 1'b0, load1 = 1'b0;
  logic [15:0] div_int1 = '0;
  logic [3:0]  div_frac1 = '0;
  logic tick_os1, tick_1x1, pending1;

  longint cyc = 0;
  int tests = 0;
  int fails = 0;
  longint q0c[$], q1c[$], seen0[$];
  logic   q0x[$], q1x[$];

  uart_baud_gen_frac dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_resync(resync),
    .i_div_int(div_int), .i_div_frac(div_frac), .i_div_load(load),
    .o_tick_os(tick_os), .o_tick_1x(tick_1x), .o_load_pending(pending)
  );

  uart_baud_gen_frac #(.OVERSAMPLE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en1), .i_resync(resync1),
    .i_div_int(div_int1), .i_div_frac(div_frac1), .i_div_load(load1),
    .o_tick_os(tick_os1), .o_tick_1x(tick_1x1), .o_load_pending(pending1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input longint target);
    while (cyc < target) step();
  endtask

  // Expected tick cycles from the divisor arithmetic, starting from a fresh phase.
  task automatic plan(input int which, input longint start, input int dint, input int dfrac,
                      input int os, input int n);
    longint t = start;
    int acc = 0;
    int s, l;
    int oc = 0;
    for (int i = 0; i < n; i++) begin
      s   = acc + dfrac;
      l   = ((dint < 2) ? 2 : dint) + ((s >= FR) ? 1 : 0);
      acc = s % FR;
      t   = t + l;
      oc  = (oc + 1) % os;
      if (which == 0) begin q0c.push_back(t); q0x.push_back(oc == 0); end
      else            begin q1c.push_back(t); q1x.push_back(oc == 0); end
    end
  endtask

  task automatic drain(input int which, input int bound);
    int n = 0;
    while (((which == 0) ? q0c.size() : q1c.size()) != 0 && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) chk("drain_timeout", (which == 0) ? q0c.size() : q1c.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tick_1x && !tick_os) chk("1x_alone", tick_1x, 0);
      if (tick_os) begin
        if (q0c.size() == 0) chk("spurious_os", tick_os, 0);
        else begin
          chk("os_cyc", cyc, q0c.pop_front());
          chk("os_1x", tick_1x, q0x.pop_front());
          seen0.push_back(cyc);
        end
      end
      if (tick_1x1 && !tick_os1) chk("os1_1x_alone", tick_1x1, 0);
      if (tick_os1) begin
        if (q1c.size() == 0) chk("os1_spurious", tick_os1, 0);
        else begin
          chk("os1_cyc", cyc, q1c.pop_front());
          chk("os1_1x", tick_1x1, q1x.pop_front());
        end
      end
    end
  end

  initial begin
    longint n0, t0, m0;

    // Reset defaults
    repeat (3) step();
    chk("rst_tick_os", tick_os, 0);
    chk("rst_tick_1x", tick_1x, 0);
    chk("rst_pending", pending, 0);
    rst = 1'b0;
    en  = 1'b1;
    n0  = cyc;
    seen0.delete();
    plan(0, n0, 325, 8, 16, 16);
    drain(0, 6000);
    en = 1'b0;
    if (seen0.size() == 16) chk("span16_default", seen0[15] - n0, 5208);
    else chk("count16_default", seen0.size(), 16);

    // Fractional accuracy, loaded while disabled
    step();
    load = 1'b1; div_int = 16'd27; div_frac = 4'd2;
    step();
    load = 1'b0; en = 1'b1;
    n0 = cyc;
    seen0.delete();
    plan(0, n0, 27, 2, 16, 1600);
    drain(0, 45000);
    en = 1'b0;
    if (seen0.size() == 1600) begin
      chk("span16_frac", seen0[15] - n0, 434);
      chk("span1600_frac", seen0[1599] - n0, 43400);
    end else chk("count_frac", seen0.size(), 1600);

    // Mid-period load applies only at the next boundary
    step();
    en = 1'b1;
    n0 = cyc;
    plan(0, n0, 27, 2, 16, 1);
    wait_until(n0 + 5);
    load = 1'b1; div_int = 16'd10; div_frac = 4'd0;
    step();
    load = 1'b0;
    chk("pend_set", pending, 1);
    wait_until(n0 + 26);
    chk("pend_hold", pending, 1);
    for (int i = 0; i < 8; i++) begin
      q0c.push_back(n0 + 27 + 10 * (i + 1));
      q0x.push_back(1'b0);
    end
    wait_until(n0 + 28);
    chk("pend_clear", pending, 0);
    drain(0, 200);
    en = 1'b0;

    // Resync mid-period, then resync coinciding with a period end
    step();
    en = 1'b1;
    n0 = cyc;
    wait_until(n0 + 5);
    resync = 1'b1;
    step();
    resync = 1'b0;
    plan(0, cyc, 10, 0, 16, 19);
    drain(0, 400);
    t0 = cyc;
    wait_until(t0 + 9);
    resync = 1'b1;
    step();
    resync = 1'b0;
    plan(0, cyc, 10, 0, 16, 16);
    drain(0, 400);
    en = 1'b0;

    // One-cycle disable mid-period, then reset with a load pending
    step();
    en = 1'b1;
    n0 = cyc;
    wait_until(n0 + 4);
    en = 1'b0;
    step();
    en = 1'b1;
    plan(0, cyc, 10, 0, 16, 3);
    drain(0, 200);
    t0 = cyc;
    wait_until(t0 + 2);
    load = 1'b1; div_int = 16'd50; div_frac = 4'd3;
    step();
    load = 1'b0;
    chk("pend_before_rst", pending, 1);
    rst = 1'b1;
    step();
    chk("pend_after_rst", pending, 0);
    chk("tick_after_rst", tick_os, 0);
    rst = 1'b0;
    m0 = cyc;
    plan(0, m0, 325, 8, 16, 2);
    drain(0, 1000);
    en = 1'b0;

    // OVERSAMPLE=1 build with clamped zero divisor
    step();
    load1 = 1'b1; div_int1 = 16'd0; div_frac1 = 4'd0;
    step();
    load1 = 1'b0; en1 = 1'b1;
    plan(1, cyc, 0, 0, 1, 20);
    drain(1, 100);
    en1 = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

- Programmable fractional-N baud tick generator.
- Produces a single-cycle oversample tick and a single-cycle bit tick for the UART TX/RX engines.
- The divisor is runtime-loadable as an integer plus fractional part; the fractional part is spread by a phase accumulator, so high baud rates stay accurate.
- A resync input lets the RX engine re-phase the ticks to a detected start-bit edge.

## Interface
- CLK_FREQ, 50_000_000: input clock frequency in Hz; used only for reset-default divisor.
- BAUD_RATE, 9600: reset-default baud rate.
- OVERSAMPLE, 16: oversample ticks per bit; legal ≥1.
- FRAC_BITS, 4: fractional divisor bits; legal 1..8.
- DIV_W, 16: integer divisor width.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  generator enable; low holds the phase at zero.
- i_resync  in  1  one-cycle pulse; restarts tick phase.
- i_div_int  in  DIV_W  integer clocks per oversample tick.
- i_div_frac  in  FRAC_BITS  fractional clocks per oversample tick, in units of 2^-FRAC_BITS.
- i_div_load  in  1  one-cycle pulse; captures i_div_int/i_div_frac into shadow.
- o_tick_os  out  1  one-cycle oversample tick.
- o_tick_1x  out  1  one-cycle bit tick, coincident with every OVERSAMPLE-th o_tick_os.
- o_load_pending  out  1  shadow divisor captured but not yet active.

## Operation
- Default divisor, computed as 64-bit localparams with truncation, not rounding:
  - DEF_INT = CLK_FREQ/(BAUD_RATE*OVERSAMPLE).
  - DEF_FRAC = ((CLK_FREQ<<FRAC_BITS)/(BAUD_RATE*OVERSAMPLE)) mod 2^FRAC_BITS.
  - For the default parameters: 325 and 8.
- State: active divisor (act_int, act_frac); shadow divisor plus pending flag; FRAC_BITS-bit phase accumulator acc; period counter cnt; period length len (DIV_W+1 bits); oversample counter os_cnt (clog2(OVERSAMPLE) bits, min 1).
- Period length:
  - At each period start: {c, acc_next} = acc + act_frac; len = act_int + c; acc <= acc_next.
  - Periods are therefore act_int or act_int+1 clocks.
  - Long periods average act_frac per 2^FRAC_BITS periods.
- Period end (cnt == len-1):
  - o_tick_os is asserted for one cycle.
  - cnt returns to 0 and the next period starts.
  - os_cnt increments, wrapping OVERSAMPLE-1 → 0.
  - o_tick_1x is asserted in the same cycle as the o_tick_os that wraps os_cnt.
  - With OVERSAMPLE=1, o_tick_1x equals o_tick_os.
- Integer clamp: act_int values 0 or 1 are treated as 2, so the minimum period is 2 clocks and ticks are never back-to-back.
- Divisor load:
  - i_div_load sets the shadow and o_load_pending.
  - The shadow becomes active at the next period boundary, or immediately if i_en is low or i_resync is high in the same cycle.
  - A second load while pending overwrites the shadow; the last value wins.
- Priority: i_rst > !i_en > i_resync > normal counting.
- While !i_en or i_resync: cnt, acc and os_cnt are cleared, and both ticks are low in that cycle.

## Timing
- Reset values:
  - o_tick_os=0, o_tick_1x=0, o_load_pending=0.
  - act=(DEF_INT, DEF_FRAC), acc=0, cnt=0, os_cnt=0.
- Outputs are registered.
- First tick: first o_tick_os occurs len clocks after the first rising edge at which i_en (or a released i_resync) is sampled.
- Subsequent ticks are exactly len clocks apart.
- Reset mid-period discards the pending load and the phase; the next tick follows the default divisor.
- Deasserting i_en mid-period drops any in-flight tick. Re-enabling starts a fresh period with acc=0.
- A load applied at a boundary affects the period that starts in that cycle; no partial period ever mixes two divisors.
- i_resync in the same cycle as a period end suppresses that tick; os_cnt restarts at 0.

## Test plan
- Reset defaults: hold i_rst 3 cycles, then i_en=1 → first o_tick_os 325 or 326 clocks later. Over 16 ticks: 16*325+8 = 5208 clocks. o_tick_1x on the 16th tick.
- Fractional accuracy: load int=27, frac=2 → long periods (28) on every 8th period. 16 oversample ticks span 434 clocks. 100 bit ticks span 43400 clocks ±1.
- Glitch-free load: mid-period load of int=10, frac=0 → o_load_pending high until the boundary. The current period keeps its old length; subsequent ticks are exactly 10 apart.
- Resync: i_resync at cnt=5 of a 10-clock period → no tick at the old boundary. Next o_tick_os 10 clocks later; o_tick_1x after 16 ticks from there.
- Clamp and OVERSAMPLE=1 build: load int=0 → ticks every 2 clocks, never adjacent. o_tick_1x identical to o_tick_os.
- Disable/reset mid-operation: drop i_en for 1 cycle mid-period → no tick until len clocks after re-enable. i_rst with a load pending → o_load_pending=0 and the default divisor is restored.
